// File: rtl/tick_arb_pkg.sv
// tick_arb_pkg
// Shared definitions for the tick arbiter slice:
//   tick_state_e    - engine state encoding (IDLE=0, DELAY=1, PULSE=2)
//   tick_arb_clog2  - ceiling log2 used to size channel-index fields
//   NCH_DEF / CHW   - default channel count and its index width
package tick_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2
    } tick_state_e;

    function automatic int tick_arb_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int NCH_DEF = 4;
    localparam int CHW     = tick_arb_clog2(NCH_DEF);

endpackage

// File: rtl/tick_arbiter_engine.sv
// tick_engine
// Delayed, stretched pulse generator shared by all channels.
//   state | meaning
//   IDLE  | waiting for start; cnt holds 0
//   DELAY | counting the snapshot delay down to 1
//   PULSE | tick high; counting the snapshot length down to 0
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   start         accept a job (only honoured in IDLE)
//   d, L          delay and length of the job, sampled on start
//   tick          registered pulse output (high while in PULSE)
//   busy          high while the engine is not IDLE
//   cnt           active down-counter value
module tick_engine
    import tick_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] d,
    input  logic [W-1:0] L,
    output logic         tick,
    output logic         busy,
    output logic [W-1:0] cnt
);

    tick_state_e  state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] len_q, len_d;
    logic         tick_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // The length is captured here so later config writes
                    // cannot reshape a job that is already running.
                    len_d = L;
                    if (d == '0) begin
                        state_d = ST_PULSE;
                        cnt_d   = L;
                    end else begin
                        state_d = ST_DELAY;
                        cnt_d   = d;
                    end
                end
            end
            ST_DELAY: begin
                if (cnt_q <= W'(1)) begin
                    state_d = ST_PULSE;
                    cnt_d   = len_q;
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            tick_q  <= (state_d == ST_PULSE);
        end
    end

    assign tick = tick_q;
    assign busy = (state_q != ST_IDLE);
    assign cnt  = cnt_q;

endmodule

// File: rtl/tick_arbiter.sv
// tick_arbiter
// Shares one delayed-pulse engine among NCH trigger requesters. Each channel
// has enable/delay/length config; a rising request edge queues the channel,
// and the arbiter hands queued channels to the engine one job at a time.
// Build option:
//   TICK_ARB_FIXED_PRIO_EN  defined  -> lowest pending index always wins
//                           undefined -> round-robin from the last grant
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   req[NCH]                         per-channel trigger levels
//   cfg_we/cfg_sel/cfg_en/
//   cfg_delay/cfg_length             one-cycle config write to one channel
//   tick                             registered output pulse
//   tick_ch                          channel of the current or last job
//   grant[NCH]                       one-hot, one cycle at each grant
//   busy                             engine not idle
//   audit[8]                         engine down-counter, resized to 8 bits
module tick_arbiter
    import tick_arb_pkg::*;
#(
    parameter  int NCH = NCH_DEF,
    parameter  int W   = 8,
    localparam int CW  = (NCH == NCH_DEF) ? CHW : tick_arb_clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NCH-1:0] req,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_sel,
    input  logic           cfg_en,
    input  logic [W-1:0]   cfg_delay,
    input  logic [W-1:0]   cfg_length,
    output logic           tick,
    output logic [CW-1:0]  tick_ch,
    output logic [NCH-1:0] grant,
    output logic           busy,
    output logic [7:0]     audit
);

    logic [NCH-1:0]        req_prev_q;
    logic [NCH-1:0]        pending_q, pending_d;
    logic [NCH-1:0]        en_q;
    logic [NCH-1:0][W-1:0] delay_q;
    logic [NCH-1:0][W-1:0] length_q;
    logic [CW-1:0]         last_q;
    logic [CW-1:0]         tick_ch_q;
    logic [NCH-1:0]        grant_q, grant_d;

    logic [CW-1:0]         winner;
    logic [CW-1:0]         idx;
    logic                  start;
    logic                  eng_busy;
    logic [W-1:0]          eng_cnt;

    // Winner search. Loops run from lowest to highest priority so the last
    // hit is the one kept.
    always_comb begin
        winner = '0;
        idx    = '0;
`ifdef TICK_ARB_FIXED_PRIO_EN
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = CW'(i);
            if (pending_q[idx]) winner = idx;
        end
`else
        for (int k = NCH; k >= 1; k--) begin
            idx = CW'((int'(last_q) + k) % NCH);
            if (pending_q[idx]) winner = idx;
        end
`endif
    end

    assign start = !eng_busy && (|pending_q);

    always_comb begin
        pending_d = pending_q;
        if (start) pending_d[winner] = 1'b0;
        // A fresh edge on the channel being granted re-queues it.
        pending_d = pending_d | (req & ~req_prev_q & en_q);
        if (cfg_we && !cfg_en) pending_d[cfg_sel] = 1'b0;
    end

    always_comb begin
        grant_d = '0;
        if (start) grant_d[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_prev_q <= '0;
            pending_q  <= '0;
            en_q       <= '0;
            delay_q    <= '0;
            length_q   <= '0;
            // Pointing at the top channel makes the first search start at 0.
            last_q     <= CW'(NCH - 1);
            tick_ch_q  <= '0;
            grant_q    <= '0;
        end else begin
            req_prev_q <= req;
            pending_q  <= pending_d;
            grant_q    <= grant_d;
            if (start) begin
                last_q    <= winner;
                tick_ch_q <= winner;
            end
            if (cfg_we) begin
                en_q[cfg_sel]     <= cfg_en;
                delay_q[cfg_sel]  <= cfg_delay;
                length_q[cfg_sel] <= cfg_length;
            end
        end
    end

    tick_engine #(.W(W)) u_engine (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .d       (delay_q[winner]),
        .L       (length_q[winner]),
        .tick    (tick),
        .busy    (eng_busy),
        .cnt     (eng_cnt)
    );

    if (W >= 8) begin : g_audit_trunc
        assign audit = eng_cnt[7:0];
    end else begin : g_audit_ext
        assign audit = {{(8 - W){1'b0}}, eng_cnt};
    end

    assign busy    = eng_busy;
    assign grant   = grant_q;
    assign tick_ch = tick_ch_q;

endmodule

// File: tb/tb_tick_arbiter.sv
module tb_tick_arbiter;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NCH-1:0] req;
    logic           cfg_we;
    logic [CW-1:0]  cfg_sel;
    logic           cfg_en;
    logic [W-1:0]   cfg_delay;
    logic [W-1:0]   cfg_length;
    logic           tick;
    logic [CW-1:0]  tick_ch;
    logic [NCH-1:0] grant;
    logic           busy;
    logic [7:0]     audit;

    always #5 clk = ~clk;

    tick_arbiter #(.NCH(NCH), .W(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_en     (cfg_en),
        .cfg_delay  (cfg_delay),
        .cfg_length (cfg_length),
        .tick       (tick),
        .tick_ch    (tick_ch),
        .grant      (grant),
        .busy       (busy),
        .audit      (audit)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Job-level reference model: a job is described by its grant cycle,
    // delay and length; outputs follow from where the current cycle falls.
    bit m_en   [NCH];
    int m_dly  [NCH];
    int m_len  [NCH];
    bit m_pend [NCH];
    bit m_prev [NCH];
    int m_last;
    int m_tch;
    int cyc;
    bit job_v;
    int job_g, job_d, job_l;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_en[i] = 0; m_dly[i] = 0; m_len[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
        end
        m_last = NCH - 1;
        m_tch  = 0;
        job_v  = 0;
        job_g  = 0; job_d = 0; job_l = 0;
    endtask

    task automatic step();
        bit             st;
        int             win;
        logic [NCH-1:0] exp_g;
        bit             inj;
        int             rel;
        int             exp_a;
        st  = 0;
        win = 0;
        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            m_reset();
        end else begin
            if (!(job_v && (cyc - 1 <= job_g + job_d + job_l))) begin
                for (int k = 1; k <= NCH; k++) begin
                    int c;
`ifdef TICK_ARB_FIXED_PRIO_EN
                    c = k - 1;
`else
                    c = (m_last + k) % NCH;
`endif
                    if (m_pend[c] && !st) begin
                        st  = 1;
                        win = c;
                    end
                end
            end
            if (st) begin
                m_pend[win] = 0;
                m_last = win;
                m_tch  = win;
                job_v  = 1;
                job_g  = cyc;
                job_d  = m_dly[win];
                job_l  = m_len[win];
            end
            for (int i = 0; i < NCH; i++)
                if (req[i] && !m_prev[i] && m_en[i]) m_pend[i] = 1;
            if (cfg_we && !cfg_en) m_pend[cfg_sel] = 0;
            for (int i = 0; i < NCH; i++) m_prev[i] = req[i];
            if (cfg_we) begin
                m_en[cfg_sel]  = cfg_en;
                m_dly[cfg_sel] = int'(cfg_delay);
                m_len[cfg_sel] = int'(cfg_length);
            end
        end
        #1;
        exp_g = '0;
        if (st) exp_g[win] = 1'b1;
        inj   = job_v && (cyc >= job_g) && (cyc <= job_g + job_d + job_l);
        rel   = cyc - job_g;
        exp_a = !inj ? 0 : ((rel < job_d) ? (job_d - rel) : (job_l - (rel - job_d)));
        chk("grant",   32'(grant),   32'(exp_g));
        chk("tick",    32'(tick),    32'(inj && (rel >= job_d)));
        chk("busy",    32'(busy),    32'(inj));
        chk("tick_ch", 32'(tick_ch), 32'(m_tch));
        chk("audit",   32'(audit),   32'(exp_a));
    endtask

    task automatic cfg_write(input int ch, input bit en, input int d, input int l);
        cfg_we     = 1'b1;
        cfg_sel    = CW'(ch);
        cfg_en     = en;
        cfg_delay  = W'(d);
        cfg_length = W'(l);
        step();
        cfg_we     = 1'b0;
    endtask

    // ch < 0 counts tick cycles of any channel
    task automatic run_count(input int n, input int ch, output int c);
        c = 0;
        repeat (n) begin
            step();
            if (tick === 1'b1 && (ch < 0 || int'(tick_ch) == ch)) c++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int order[$];
        reset_n = 1'b0; req = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_en = 1'b0;
        cfg_delay = '0; cfg_length = '0;
        cyc = 0;
        m_reset();
        #2;
        chk("rst_tick",  32'(tick), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tch",   32'(tick_ch), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // 1: ch0 d=3 L=2
        cfg_write(0, 1, 3, 2);
        req = 4'b0001; step();                      // E0
        step(); chk("t1_grant", 32'(grant), 32'h1); // E1
        chk("t1_tch", 32'(tick_ch), 32'd0);
        step(); step(); chk("t1_pre",  32'(tick), 32'd0); // E3
        step();         chk("t1_rise", 32'(tick), 32'd1); // E4
        step(); step(); chk("t1_hold", 32'(tick), 32'd1); // E6
        step();         chk("t1_fall", 32'(tick), 32'd0); // E7

        // 2: ch1 d=0 L=0
        cfg_write(1, 1, 0, 0);
        req = 4'b0011; step();
        step(); chk("t2_tick", 32'(tick), 32'd1); chk("t2_busy", 32'(busy), 32'd1);
        step(); chk("t2_tick_end", 32'(tick), 32'd0); chk("t2_busy_end", 32'(busy), 32'd0);

        // 3: simultaneous requests from a clean reset
        req = '0;
        do_reset();
        cfg_write(0, 1, 3, 2);
        cfg_write(1, 1, 0, 1);
        cfg_write(2, 1, 0, 1);
        cfg_write(3, 1, 0, 1);
        req = 4'b1110;
        repeat (16) begin
            step();
            for (int i = 0; i < NCH; i++) if (grant[i] === 1'b1) order.push_back(i);
        end
        chk("t3_count", 32'(order.size()), 32'd3);
        if (order.size() >= 3) begin
            chk("t3_first",  32'(order[0]), 32'd1);
            chk("t3_second", 32'(order[1]), 32'd2);
            chk("t3_third",  32'(order[2]), 32'd3);
        end
        order.delete();
        req = '0; step();
        req = 4'b0011;
        repeat (20) begin
            step();
            for (int i = 0; i < NCH; i++) if (grant[i] === 1'b1) order.push_back(i);
        end
        chk("t3b_count", 32'(order.size()), 32'd2);
        if (order.size() >= 1) chk("t3b_first", 32'(order[0]), 32'd0);

        // 4: reconfigure the active channel mid-delay
        cfg_write(2, 1, 5, 1);
        req = '0; step();
        req = 4'b0100; step();  // E0
        step();                 // E1 grant
        step();                 // E2
        cfg_write(2, 1, 1, 4);
        run_count(12, 2, c);
        chk("t4_old_len", 32'(c), 32'd2);
        req = '0; step();
        req = 4'b0100; step();
        step(); chk("t4_grant", 32'(grant), 32'h4); chk("t4_gap", 32'(tick), 32'd0);
        run_count(12, 2, c);
        chk("t4_new_len", 32'(c), 32'd5);

        // 5: disabling a pending channel, held request after re-enable
        cfg_write(0, 1, 20, 0);
        req = '0; step();
        req = 4'b0001; step(); step();
        req = 4'b1001; step();
        cfg_write(3, 0, 0, 1);
        cfg_write(3, 1, 0, 1);
        run_count(30, 3, c);
        chk("t5_no_ch3", 32'(c), 32'd0);
        req = 4'b0001; step();
        req = 4'b1001;
        run_count(10, 3, c);
        chk("t5_ch3_after_edge", 32'(c), 32'd2);

        // 6: asynchronous reset mid-pulse
        cfg_write(1, 1, 0, 10);
        req = '0; step();
        req = 4'b0010; step(); step(); step(); step();
        chk("t6_in_pulse", 32'(tick), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_async_tick", 32'(tick), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        m_reset();
        step();
        reset_n = 1'b1;
        run_count(15, -1, c);
        chk("t6_no_resume", 32'(c), 32'd0);

        // maximum delay, no wrap
        cfg_write(0, 1, 255, 0);
        req = 4'b0001; step();
        run_count(262, 0, c);
        chk("max_delay_ticks", 32'(c), 32'd1);

        // randomized traffic checked cycle by cycle
        req = '0;
        repeat (2500) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            if ($urandom_range(0, 9) == 0) begin
                cfg_we     = 1'b1;
                cfg_sel    = CW'($urandom_range(0, NCH - 1));
                cfg_en     = ($urandom_range(0, 3) != 0);
                cfg_delay  = W'($urandom_range(0, 6));
                cfg_length = W'($urandom_range(0, 4));
            end
            step();
            cfg_we = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
